// File: rtl/fir_output_requantizer_fifo.sv
// rtl/fir_output_requantizer_fifo.sv - round/shift/saturate FIR results into a show-ahead FIFO
module fir_output_requantizer_fifo #(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en,
  input  logic [IN_WIDTH-1:0]                iv_din,
  input  logic                               i_din_valid,
  output logic                               o_ready,
  output logic [OUT_WIDTH-1:0]               ov_dout,
  output logic                               o_dout_valid,
  input  logic                               i_ready,
  output logic                               o_sat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    ov_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [OUT_WIDTH-1:0]   cap_data;
  logic                   cap_sat;
  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic signed [IN_WIDTH:0] din_ext;
  logic signed [IN_WIDTH:0] t;
  logic [OUT_WIDTH-1:0]     q_data;
  logic                     q_sat;
  logic                     full, empty, accept, wr_en, pop;

  // One extra bit of headroom so the rounding add cannot overflow.
  assign din_ext = {iv_din[IN_WIDTH-1], iv_din};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (SHIFT-1);
      logic signed [IN_WIDTH:0] sum;
      assign sum = din_ext + HALF;
      assign t   = sum >>> SHIFT;
    end else begin : g_pass
      assign t = din_ext;
    end
  endgenerate

  // Clip the shifted value into the signed OUT_WIDTH range and flag clipping.
  always_comb begin
    q_data = t[OUT_WIDTH-1:0];
    q_sat  = 1'b0;
    if (t > SAT_MAX) begin
      q_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      q_sat  = 1'b1;
    end else if (t < SAT_MIN) begin
      q_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      q_sat  = 1'b1;
    end
  end

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign accept = i_en && (state == IDLE) && i_din_valid && !full;
  assign wr_en  = i_en && (state == ACK);
  assign pop    = o_dout_valid && i_ready;

  // Input handshake state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else if (i_en) state <= state_nxt;
  end

  // Next state: one accept, one ack cycle, one dead cycle for upstream to drop valid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACK;
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture register, pointers and occupancy; everything freezes while i_en is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cap_data <= '0;
      cap_sat  <= 1'b0;
    end else if (i_en) begin
      if (accept) begin
        cap_data <= q_data;
        cap_sat  <= q_sat;
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= cap_data;
  end

  assign o_ready      = (state == ACK);
  assign o_sat        = (state == ACK) && cap_sat;
  assign o_dout_valid = !empty && i_en;
  assign ov_dout      = empty ? '0 : mem[rd_ptr];
  assign ov_count     = count;

endmodule

// File: tb/tb_fir_output_requantizer_fifo.sv
// tb/tb_fir_output_requantizer_fifo.sv - directed checks for fir_output_requantizer_fifo
module tb_fir_output_requantizer_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [23:0] iv_din;
  logic        i_din_valid;
  logic        o_ready;
  logic [15:0] ov_dout;
  logic        o_dout_valid;
  logic        i_ready;
  logic        o_sat;
  logic [3:0]  ov_count;

  int n_vec = 0;
  int n_err = 0;

  fir_output_requantizer_fifo #(
    .IN_WIDTH(24), .OUT_WIDTH(16), .SHIFT(8), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .o_ready(o_ready), .ov_dout(ov_dout),
    .o_dout_valid(o_dout_valid), .i_ready(i_ready), .o_sat(o_sat),
    .ov_count(ov_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (o_ready !== 1'b1 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, " ack"}, 32'(o_ready), 32'd1);
  endtask

  task automatic push(input logic [23:0] d, input logic exp_sat, input string tag);
    iv_din      = d;
    i_din_valid = 1'b1;
    wait_ready(tag);
    check({tag, " sat"}, 32'(o_sat), 32'(exp_sat));
    i_din_valid = 1'b0;
    @(negedge i_clk);
    check({tag, " pulse"}, 32'(o_ready), 32'd0);
  endtask

  initial begin
    int seen;
    i_rst_n     = 1'b0;
    i_en        = 1'b1;
    iv_din      = '0;
    i_din_valid = 1'b0;
    i_ready     = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst ready", 32'(o_ready), 32'd0);
    check("rst sat", 32'(o_sat), 32'd0);
    check("rst valid", 32'(o_dout_valid), 32'd0);
    check("rst dout", 32'(ov_dout), 32'd0);
    check("rst count", 32'(ov_count), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // rounding and saturation, sink always ready
    i_ready = 1'b1;
    check("idle valid", 32'(o_dout_valid), 32'd0);
    push(24'h000180, 1'b0, "rnd_a");
    check("rnd_a dout", 32'(ov_dout), 32'h0002);
    check("rnd_a valid", 32'(o_dout_valid), 32'd1);
    push(24'h00017F, 1'b0, "rnd_b");
    check("rnd_b dout", 32'(ov_dout), 32'h0001);
    push(24'hFFFE80, 1'b0, "rnd_c");
    check("rnd_c dout", 32'(ov_dout), 32'hFFFF);
    push(24'h7FFFFF, 1'b1, "sat_max");
    check("sat_max dout", 32'(ov_dout), 32'h7FFF);
    push(24'h800000, 1'b0, "sat_min");
    check("sat_min dout", 32'(ov_dout), 32'h8000);
    push(24'h7FFF80, 1'b1, "sat_edge");
    check("sat_edge dout", 32'(ov_dout), 32'h7FFF);
    @(negedge i_clk);
    check("rnd drained", 32'(ov_count), 32'd0);

    // fill to full with sink stalled
    i_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push(24'(k << 8), 1'b0, $sformatf("fill%0d", k));
    check("full count", 32'(ov_count), 32'd8);
    check("full head", 32'(ov_dout), 32'd1);
    iv_din      = 24'(9 << 8);
    i_din_valid = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_ready === 1'b1) seen = 1;
    end
    check("full stall", 32'(seen), 32'd0);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("pop head", 32'(ov_dout), 32'd2);
    check("pop count", 32'(ov_count), 32'd7);
    wait_ready("ninth");
    i_din_valid = 1'b0;
    @(negedge i_clk);
    check("ninth count", 32'(ov_count), 32'd8);
    i_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("drain%0d", k), 32'(ov_dout), 32'(k));
      @(negedge i_clk);
    end
    i_ready = 1'b0;
    check("drain count", 32'(ov_count), 32'd0);
    check("drain valid", 32'(o_dout_valid), 32'd0);

    // write and pop on the same edge
    push(24'h000A00, 1'b0, "sp_a");
    check("sp_a count", 32'(ov_count), 32'd1);
    iv_din      = 24'h000B00;
    i_din_valid = 1'b1;
    wait_ready("sp_b");
    i_din_valid = 1'b0;
    i_ready     = 1'b1;
    check("sp_b head", 32'(ov_dout), 32'd10);
    @(negedge i_clk);
    check("sp same count", 32'(ov_count), 32'd1);
    check("sp same head", 32'(ov_dout), 32'd11);
    @(negedge i_clk);
    check("sp empty", 32'(ov_count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      push(24'((20 + k) << 8), 1'b0, $sformatf("b2b%0d", k));
      check($sformatf("b2b%0d dout", k), 32'(ov_dout), 32'(20 + k));
      check($sformatf("b2b%0d count", k), 32'(ov_count), 32'd1);
    end
    @(negedge i_clk);
    i_ready = 1'b0;

    // asynchronous reset during ACK with three words buffered
    for (int k = 0; k < 3; k++) push(24'((30 + k) << 8), 1'b0, $sformatf("pre%0d", k));
    check("pre count", 32'(ov_count), 32'd3);
    iv_din      = 24'(33 << 8);
    i_din_valid = 1'b1;
    wait_ready("rst_ack");
    #2 i_rst_n = 1'b0;
    #1;
    check("arst ready", 32'(o_ready), 32'd0);
    check("arst sat", 32'(o_sat), 32'd0);
    check("arst valid", 32'(o_dout_valid), 32'd0);
    check("arst dout", 32'(ov_dout), 32'd0);
    check("arst count", 32'(ov_count), 32'd0);
    @(negedge i_clk);
    i_din_valid = 1'b0;
    i_rst_n     = 1'b1;
    @(negedge i_clk);
    push(24'h000180, 1'b0, "post_rst");
    check("post_rst dout", 32'(ov_dout), 32'h0002);
    check("post_rst count", 32'(ov_count), 32'd1);

    // enable dropped during ACK
    iv_din      = 24'h7FFFFF;
    i_din_valid = 1'b1;
    wait_ready("en_ack");
    i_en        = 1'b0;
    i_din_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    check("en_off ready", 32'(o_ready), 32'd1);
    check("en_off sat", 32'(o_sat), 32'd1);
    check("en_off valid", 32'(o_dout_valid), 32'd0);
    check("en_off count", 32'(ov_count), 32'd1);
    i_en = 1'b1;
    @(negedge i_clk);
    check("en_on ready", 32'(o_ready), 32'd0);
    check("en_on count", 32'(ov_count), 32'd2);
    check("en_on valid", 32'(o_dout_valid), 32'd1);
    i_ready = 1'b1;
    check("en_drain0", 32'(ov_dout), 32'h0002);
    @(negedge i_clk);
    check("en_drain1", 32'(ov_dout), 32'h7FFF);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("en_drain count", 32'(ov_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_output_requantizer_fifo.md
Name: fir_output_requantizer_fifo

Overview:
Downstream stage of the FIR filter. It consumes each full-width filter result through the filter's valid/ready-pulse handshake and applies round-half-up plus arithmetic right shift. The result is saturated to OUT_WIDTH and buffered in a small circular FIFO. The FIFO drains to the DAC/serializer side over a valid/ready streaming interface, decoupling filter compute time from the sink's consumption rate.

Parameters:
IN_WIDTH, 24, width of the signed filter result (iv_din).
OUT_WIDTH, 16, width of the signed requantized output (ov_dout); OUT_WIDTH <= IN_WIDTH.
SHIFT, 8, arithmetic right shift applied before saturation; 0 = no shift, no rounding.
FIFO_DEPTH, 8, number of buffered output words; power of 2, >= 2.

Ports:
i_clk  in  1  single clock, rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_en  in  1  global enable; low freezes all state.
iv_din  in  IN_WIDTH  signed filter result from upstream.
i_din_valid  in  1  upstream result valid; held until o_ready pulse seen.
o_ready  out  1  one-cycle pulse: current iv_din has been consumed.
ov_dout  out  OUT_WIDTH  signed requantized word at FIFO head.
o_dout_valid  out  1  FIFO non-empty and i_en high.
i_ready  in  1  sink accepts; transfer when o_dout_valid & i_ready at rising edge.
o_sat  out  1  one-cycle pulse, concurrent with o_ready, when the captured sample was clipped.
ov_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; wr/rd pointers 0; count 0; capture reg 0; o_ready=0, o_sat=0, o_dout_valid=0, ov_dout=0, ov_count=0. Reset mid-transfer discards the pending capture; no partial write.
- Input FSM: IDLE -> ACK -> GAP -> IDLE.
  - IDLE: at an edge with i_en=1, i_din_valid=1 and count < FIFO_DEPTH: capture requantize(iv_din) and the sat flag, go to ACK. Otherwise stay.
  - ACK: o_ready=1, o_sat=flag, both registered. At the next enabled edge, write the capture into mem[wr_ptr], increment wr_ptr (wraps mod FIFO_DEPTH), go to GAP.
  - GAP: o_ready=0; i_din_valid ignored; next enabled edge goes to IDLE. Upstream must drop or renew valid within one cycle of seeing o_ready.
- Requantize, in IN_WIDTH+1 bits:
  - If SHIFT>0: t = (sext(iv_din) + 2^(SHIFT-1)) >>> SHIFT. If SHIFT=0: t = iv_din.
  - If t > 2^(OUT_WIDTH-1)-1, output max and flag=1. If t < -2^(OUT_WIDTH-1), output min and flag=1. Otherwise output t[OUT_WIDTH-1:0] and flag=0.
- Output side (show-ahead FIFO):
  - ov_dout = mem[rd_ptr], driven from registers; no read latency.
  - o_dout_valid = (count != 0) & i_en.
  - A pop on transfer increments rd_ptr (wraps).
  - ov_dout content is don't-care when empty, but must be stable while valid & !i_ready.
- Count:
  - Write and pop at the same edge: count unchanged.
  - Pop when empty: impossible, since valid is low.
  - Full (count = FIFO_DEPTH): IDLE does not accept; o_ready stays low and upstream stalls. Only one write is ever in flight, so the full check at capture is sufficient.
- Latency: i_din_valid sampled at edge E0 (IDLE, not full) -> o_ready high cycle E0..E1 -> written at E1 -> o_dout_valid high after E1 if the FIFO was empty. Minimum accept spacing is 3 cycles.
- i_en=0: no state, pointer, count or capture update; o_ready/o_sat hold their registered value; o_dout_valid forced 0, so no pop.

Test Plan:
- Rounding, SHIFT=8: iv_din 0x000180 -> ov_dout 0x0002; 0x00017F -> 0x0001; 0xFFFE80 -> 0xFFFF; o_sat=0 for all three; o_ready exactly one cycle per sample, o_dout_valid 2 edges after valid sampled.
- Saturation: iv_din 0x7FFFFF -> 0x7FFF with o_sat pulse; 0x800000 -> 0x8000 with o_sat=0; 0x7FFF80 -> 0x7FFF with o_sat=1.
- Full/backpressure: i_ready=0, push 9 samples 1..9 (<<8) -> first 8 acked, ov_count=8, 9th gets no o_ready. Then raise i_ready for one cycle -> pop value 1, 9th acked; drain yields 2..9 in order, with pointer wrap verified.
- Simultaneous push/pop: i_ready=1 continuously with back-to-back inputs -> ov_count never exceeds 1, output order preserved.
- Reset mid-operation: deassert i_rst_n during ACK with 3 words buffered -> all outputs 0 immediately (asynchronously), ov_count=0. After release, the first new sample is output correctly.
- Enable gating: drop i_en during ACK for 5 cycles -> o_ready held, no write, o_dout_valid=0. On re-enable, write completes and count increments by exactly 1.
